// File: rtl/core_pkg.sv
// Shared types for the core control path: FSM states and the
// bundled pipeline enable/flush controls.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN   = 8'b11111_000;
    localparam pipe_ctrl_t CTRL_MEM   = 8'b00001_001;
    localparam pipe_ctrl_t CTRL_BR    = 8'b11111_110;
    localparam pipe_ctrl_t CTRL_LU    = 8'b00111_010;
    localparam pipe_ctrl_t CTRL_HALT  = 8'b00000_000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, branch redirect and memory-wait
// hazards, with a wait timeout FSM and saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W  = core_pkg::REG_ADDR_W,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      cnt_load_use,
    output logic [CNT_W-1:0]      cnt_mem_wait,
    output logic [CNT_W-1:0]      cnt_branch
);

    import core_pkg::*;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t    state;
    logic [WCW-1:0] wait_cnt;
    pipe_ctrl_t     ctrl;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic win_mem;
    logic win_br;
    logic win_lu;

    assign mem_stall = mem_req & ~mem_ready;
    assign rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
    assign rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
    assign load_use  = ex_mem_read & (ex_rd != '0)
                     & (rs1_hit | rs2_hit);

    // Priority: ERROR > memory stall > branch > load-use.
    always_comb begin
        ctrl    = CTRL_RUN;
        win_mem = 1'b0;
        win_br  = 1'b0;
        win_lu  = 1'b0;
        if (rst || state == ERROR) begin
            ctrl = CTRL_HALT;
        end else if (mem_stall) begin
            ctrl    = CTRL_MEM;
            win_mem = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl   = CTRL_BR;
            win_br = 1'b1;
        end else if (load_use) begin
            ctrl   = CTRL_LU;
            win_lu = 1'b1;
        end
    end

    assign pc_we        = ctrl.pc_we;
    assign if_id_we     = ctrl.if_id_we;
    assign id_ex_we     = ctrl.id_ex_we;
    assign ex_mem_we    = ctrl.ex_mem_we;
    assign mem_wb_we    = ctrl.mem_wb_we;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign mem_timeout  = (state == ERROR);

    // wait_cnt holds the number of stall cycles already seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_lu (
        .clk   (clk),
        .rst   (rst),
        .inc   (win_lu),
        .count (cnt_load_use)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mem (
        .clk   (clk),
        .rst   (rst),
        .inc   (win_mem),
        .count (cnt_mem_wait)
    );

    sat_counter #(.W(CNT_W)) u_cnt_br (
        .clk   (clk),
        .rst   (rst),
        .inc   (win_br),
        .count (cnt_branch)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a scoreboard of
// expected control vectors.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 5;
    localparam int CW = 2;
    localparam int TO = 4;

    // {pc, if_id, id_ex, ex_mem, mem_wb we, if_id, id_ex, mem_wb flush, timeout}
    localparam logic [8:0] E_RUN = 9'b11111_000_0;
    localparam logic [8:0] E_LU  = 9'b00111_010_0;
    localparam logic [8:0] E_BR  = 9'b11111_110_0;
    localparam logic [8:0] E_MEM = 9'b00001_001_0;
    localparam logic [8:0] E_ERR = 9'b00000_000_1;
    localparam logic [8:0] E_RST = 9'b00000_000_0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [RW-1:0] id_rs1 = '0;
    logic [RW-1:0] id_rs2 = '0;
    logic          id_uses_rs1 = 1'b0;
    logic          id_uses_rs2 = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic [RW-1:0] ex_rd = '0;
    logic          ex_branch_taken = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout;
    logic [CW-1:0] cnt_load_use, cnt_mem_wait, cnt_branch;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .id_ex_we       (id_ex_we),
        .ex_mem_we      (ex_mem_we),
        .mem_wb_we      (mem_wb_we),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .mem_wb_flush   (mem_wb_flush),
        .mem_timeout    (mem_timeout),
        .cnt_load_use   (cnt_load_use),
        .cnt_mem_wait   (cnt_mem_wait),
        .cnt_branch     (cnt_branch)
    );

    always #5 clk = ~clk;

    task automatic check_ctrl(input string tag);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
               if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [8:0] exp);
        sb.push_back(exp);
        #1;
        check_ctrl(tag);
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] obs,
                             input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic mr,
                         input logic [RW-1:0] rd, input logic br,
                         input logic req, input logic rdy,
                         input logic [8:0] exp);
        @(negedge clk);
        id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd;
        ex_branch_taken = br;
        mem_req = req; mem_ready = rdy;
        expect_now(tag, exp);
    endtask

    task automatic idle(input string tag, input logic [8:0] exp);
        drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
        expect_now("reset_ctrl", E_RST);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        expect_now("por_ctrl", E_RST);
        check_cnt("por_cnt_lu", cnt_load_use, 2'd0);
        check_cnt("por_cnt_mem", cnt_mem_wait, 2'd0);
        check_cnt("por_cnt_br", cnt_branch, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_now("run_default", E_RUN);

        // load-use on rs1, then rd=0, rs2 hit, unused rs1
        drive("lu_rs1", 5, 0, 1, 0, 1, 5, 0, 0, 0, E_LU);
        @(posedge clk); #1;
        check_cnt("lu_cnt1", cnt_load_use, 2'd1);
        drive("lu_rd0", 0, 0, 1, 0, 1, 0, 0, 0, 0, E_RUN);
        drive("lu_rs2", 1, 7, 1, 1, 1, 7, 0, 0, 0, E_LU);
        drive("lu_nouse", 9, 0, 0, 0, 1, 9, 0, 0, 0, E_RUN);
        drive("no_load", 9, 0, 1, 0, 0, 9, 0, 0, 0, E_RUN);
        @(posedge clk); #1;
        check_cnt("lu_cnt2", cnt_load_use, 2'd2);

        // branch wins over a coincident load-use
        do_reset();
        drive("br_lu", 5, 0, 1, 0, 1, 5, 1, 0, 0, E_BR);
        idle("br_after", E_RUN);
        check_cnt("br_cnt", cnt_branch, 2'd1);
        check_cnt("br_cnt_lu", cnt_load_use, 2'd0);

        // memory wait of 3 cycles; first stall cycle also has a branch
        do_reset();
        drive("mem_w1", 5, 0, 1, 0, 1, 5, 1, 1, 0, E_MEM);
        drive("mem_w2", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
        drive("mem_w3", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
        drive("mem_rel", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN);
        idle("mem_idle", E_RUN);
        check_cnt("mem_cnt", cnt_mem_wait, 2'd3);
        check_cnt("mem_cnt_br", cnt_branch, 2'd0);
        check_cnt("mem_cnt_lu", cnt_load_use, 2'd0);

        // timeout: entry stall plus TO cycles in MEM_WAIT, then ERROR
        for (int i = 0; i <= TO; i++)
            drive("to_stall", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
        drive("to_err", 0, 0, 0, 0, 0, 0, 0, 1, 1, E_ERR);
        idle("to_hold", E_ERR);
        drive("to_hold_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, E_ERR);

        // asynchronous reset between edges while waiting
        do_reset();
        expect_now("post_err_run", E_RUN);
        drive("ar_w1", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
        drive("ar_w2", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_MEM);
        @(negedge clk);
        #2;
        rst = 1'b1;
        expect_now("ar_ctrl", E_RST);
        check_cnt("ar_cnt_mem", cnt_mem_wait, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b0;
        expect_now("ar_release", E_RUN);
        idle("ar_run", E_RUN);
        check_cnt("ar_cnt_mem2", cnt_mem_wait, 2'd0);

        // saturation: 5 load-use events into a 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive("sat_lu", 0, 3, 0, 1, 1, 3, 0, 0, 0, E_LU);
            idle("sat_gap", E_RUN);
        end
        check_cnt("sat_cnt", cnt_load_use, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
